// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_pkg
// Description : Shared constants and scheduler state encoding for the display.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_display_pkg;

    localparam int SR_WORD_W  = 16;
    localparam int MAX_DIGITS = 8;
    localparam int SEL_LSB    = 8;
    localparam int DP_BIT     = 7;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD        = 2'd1,
        ST_WAIT_ACCEPT = 2'd2,
        ST_WAIT_DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Hex nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_7seg (
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_value)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_refresh_scheduler
// Description : Multiplexed seven-segment refresh; feeds a 16-bit serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_refresh_scheduler
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 16000
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [2:0]           i_wr_digit,
    input  logic [3:0]           i_wr_value,
    input  logic                 i_wr_dp,
    output logic [SR_WORD_W-1:0] o_sr_value,
    output logic                 o_sr_start,
    input  logic                 i_sr_busy,
    output logic [2:0]           o_digit_idx,
    output logic                 o_frame_tick,
    output logic                 o_overrun
);

    localparam int                 TIMER_W    = $clog2(REFRESH_DIV);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_DIV - 1);
    localparam logic [2:0]         IDX_LAST   = 3'(NUM_DIGITS - 1);

    logic [4:0]           r_buf [MAX_DIGITS];
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_pending;
    logic                 r_overrun;
    state_t               r_state;
    logic [2:0]           r_idx;
    logic [SR_WORD_W-1:0] r_sr_value;
    logic                 r_sr_start;
    logic                 r_frame_tick;
    logic                 r_wr_ready;

    logic                 w_tick;
    logic                 w_consume;
    logic                 w_wr_keep;
    logic [4:0]           w_entry;
    logic [6:0]           w_seg;
    logic [SR_WORD_W-1:0] w_word;

    assign w_tick    = (r_timer == TIMER_LAST);
    assign w_consume = (r_state == ST_IDLE) && r_pending;
    assign w_wr_keep = ({1'b0, i_wr_digit} < 4'(NUM_DIGITS));
    assign w_entry   = r_buf[r_idx];

    hex_to_7seg u_decode (
        .i_value (w_entry[3:0]),
        .o_seg   (w_seg)
    );

    always_comb begin
        w_word = '0;
        if (i_enable) begin
            w_word[SEL_LSB +: MAX_DIGITS] = 8'b1 << r_idx;
            w_word[DP_BIT]                = w_entry[4];
            w_word[6:0]                   = w_seg;
        end
    end

    // Out-of-range digits still complete the handshake; they are just dropped.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                r_buf[i] <= 5'd0;
            end
        end else if (i_wr_valid && r_wr_ready && w_wr_keep) begin
            r_buf[i_wr_digit] <= {i_wr_dp, i_wr_value};
        end
    end

    // A tick landing on the consume cycle re-arms pending without an overrun.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + TIMER_W'(1);
            if (w_tick) begin
                r_pending <= 1'b1;
                if (r_pending && !w_consume) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= 3'd0;
            r_sr_value   <= '0;
            r_sr_start   <= 1'b0;
            r_frame_tick <= 1'b0;
            r_wr_ready   <= 1'b0;
        end else begin
            r_sr_start   <= 1'b0;
            r_frame_tick <= 1'b0;
            r_wr_ready   <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (r_pending) begin
                        r_state    <= ST_LOAD;
                        r_sr_value <= w_word;
                        r_sr_start <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_WAIT_ACCEPT;
                end
                ST_WAIT_ACCEPT: begin
                    if (i_sr_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_sr_busy) begin
                        r_state <= ST_IDLE;
                        if (r_idx == IDX_LAST) begin
                            r_idx        <= 3'd0;
                            r_frame_tick <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_wr_ready   = r_wr_ready;
    assign o_sr_value   = r_sr_value;
    assign o_sr_start   = r_sr_start;
    assign o_digit_idx  = r_idx;
    assign o_frame_tick = r_frame_tick;
    assign o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seg_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_refresh_scheduler
// Description : Scoreboard bench for seg_refresh_scheduler with a serializer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_refresh_scheduler;

    localparam int ND  = 4;
    localparam int DIV = 8;

    typedef struct packed {
        logic [15:0] word;
        logic [2:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_digit = 3'd0;
    logic [3:0]  wr_value = 4'd0;
    logic        wr_dp = 1'b0;
    logic [15:0] sr_value;
    logic        sr_start;
    logic        sr_busy = 1'b0;
    logic [2:0]  digit_idx;
    logic        frame_tick;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          base = 0;
    int          n_starts = 0;
    int          last_start_cyc = 0;
    int          n_frames = 0;
    logic [2:0]  frame_idx = 3'd0;
    int          busy_len = 3;
    int          busy_cnt = 0;
    logic [15:0] held = 16'h0;
    exp_t        sb_q[$];
    logic [4:0]  mbuf [ND];
    int          exp_idx = 0;
    logic        en_m = 1'b1;

    seg_refresh_scheduler #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_enable     (enable),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_digit   (wr_digit),
        .i_wr_value   (wr_value),
        .i_wr_dp      (wr_dp),
        .o_sr_value   (sr_value),
        .o_sr_start   (sr_start),
        .i_sr_busy    (sr_busy),
        .o_digit_idx  (digit_idx),
        .o_frame_tick (frame_tick),
        .o_overrun    (overrun)
    );

    initial forever #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Serializer: busy rises at the start pulse and holds busy_len cycles.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            sr_busy  = 1'b0;
            busy_cnt = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) sr_busy = 1'b0;
        end else if (sr_start) begin
            sr_busy  = 1'b1;
            busy_cnt = busy_len;
        end
    end

    // Scoreboard pop on every start; word must otherwise stay put.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            held = 16'h0;
        end else begin
            if (sr_start) begin
                n_starts++;
                last_start_cyc = cyc;
                held = sr_value;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: got word %h idx %0d, none expected", sr_value, digit_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (sr_value !== e.word || digit_idx !== e.idx) begin
                        errors++;
                        $display("FAIL sb_word: got %h idx %0d expected %h idx %0d", sr_value, digit_idx, e.word, e.idx);
                    end
                end
            end else begin
                checks++;
                if (sr_value !== held) begin
                    errors++;
                    $display("FAIL word_stable: got %h expected %h", sr_value, held);
                end
            end
            if (frame_tick) begin
                n_frames++;
                frame_idx = digit_idx;
            end
        end
    end

    task automatic push_slot();
        logic [15:0] w;
        w = 16'h0;
        if (en_m) w = {8'(1 << exp_idx), mbuf[exp_idx][4], seg7(mbuf[exp_idx][3:0])};
        sb_q.push_back({w, 3'(exp_idx)});
        exp_idx = (exp_idx + 1) % ND;
    endtask

    task automatic wait_starts(input int n);
        int target;
        int budget;
        target = n_starts + n;
        budget = n * 40;
        while (n_starts < target && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (n_starts < target) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: got %0d starts expected %0d", n_starts, target);
        end
    endtask

    task automatic do_write(input logic [2:0] d, input logic [3:0] v, input logic dp);
        int budget;
        budget = 20;
        wr_valid = 1'b1;
        wr_digit = d;
        wr_value = v;
        wr_dp    = dp;
        while (!wr_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL write_handshake: got ready %b expected 1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        if (d < ND) mbuf[d] = {dp, v};
    endtask

    task automatic test_reset();
        for (int i = 0; i < ND; i++) mbuf[i] = 5'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sr_value, sr_start, digit_idx, frame_tick, overrun, wr_ready} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {sr_value, sr_start, digit_idx, frame_tick, overrun, wr_ready});
        end
        rst_n = 1'b1;
        base  = cyc;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", wr_ready);
        end
    endtask

    task automatic test_write_dp();
        do_write(3'd2, 4'hA, 1'b1);
        repeat (3) push_slot();
        wait_starts(1);
        checks++;
        if (last_start_cyc - base !== 9) begin
            errors++;
            $display("FAIL first_start_latency: got %0d expected 9", last_start_cyc - base);
        end
        wait_starts(2);
    endtask

    task automatic test_scan();
        int f0;
        f0 = n_frames;
        repeat (2) push_slot();
        wait_starts(2);
        checks++;
        if (n_frames - f0 !== 1 || frame_idx !== 3'd0) begin
            errors++;
            $display("FAIL frame_tick: got %0d ticks idx %0d expected 1 idx 0", n_frames - f0, frame_idx);
        end
        repeat (2) push_slot();
        wait_starts(2);
        checks++;
        if (n_frames - f0 !== 1) begin
            errors++;
            $display("FAIL frame_tick_extra: got %0d ticks expected 1", n_frames - f0);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        en_m   = 1'b0;
        push_slot();
        wait_starts(1);
        enable = 1'b1;
        en_m   = 1'b1;
        push_slot();
        wait_starts(1);
    endtask

    task automatic test_overrun();
        int s;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
        busy_len = 2 * DIV;
        push_slot();
        wait_starts(1);
        s = last_start_cyc;
        @(negedge clk);
        busy_len = 3;
        repeat (2) push_slot();
        wait_starts(1);
        checks++;
        if (last_start_cyc - s !== 18) begin
            errors++;
            $display("FAIL overrun_restart: got gap %0d expected 18", last_start_cyc - s);
        end
        s = last_start_cyc;
        wait_starts(1);
        checks++;
        if (last_start_cyc - s !== 6 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_single: got gap %0d ovr %b expected 6 ovr 1", last_start_cyc - s, overrun);
        end
        push_slot();
        wait_starts(1);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b expected 1", overrun);
        end
    endtask

    task automatic test_bad_digit();
        do_write(3'd5, 4'hF, 1'b1);
        do_write(3'd3, 4'h1, 1'b0);
        do_write(3'd3, 4'h7, 1'b1);
        repeat (4) push_slot();
        wait_starts(4);
    endtask

    task automatic test_load_write();
        int          k;
        logic [15:0] w;
        k = exp_idx;
        push_slot();
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (sr_start !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready: got start %b ready %b expected 1 0", sr_start, wr_ready);
        end
        w        = sr_value;
        wr_valid = 1'b1;
        wr_digit = 3'(k);
        wr_value = 4'h5;
        wr_dp    = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_write_accept: got ready %b expected 1", wr_ready);
        end
        @(negedge clk);
        #1;
        wr_valid = 1'b0;
        mbuf[k]  = {1'b0, 4'h5};
        checks++;
        if (sr_value !== w) begin
            errors++;
            $display("FAIL inflight_word: got %h expected %h", sr_value, w);
        end
        repeat (ND) push_slot();
        wait_starts(ND);
    endtask

    task automatic test_mid_reset();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", sb_q.size());
        end
        push_slot();
        wait_starts(1);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sr_value, sr_start, digit_idx, frame_tick, overrun, wr_ready} !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h expected 0",
                     {sr_value, sr_start, digit_idx, frame_tick, overrun, wr_ready});
        end
        for (int i = 0; i < ND; i++) mbuf[i] = 5'd0;
        exp_idx = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        push_slot();
        wait_starts(1);
        checks++;
        if (last_start_cyc - base !== 9) begin
            errors++;
            $display("FAIL restart_latency: got %0d expected 9", last_start_cyc - base);
        end
    endtask

    initial begin
        test_reset();
        test_write_dp();
        test_scan();
        test_enable();
        test_overrun();
        test_bad_digit();
        test_load_write();
        test_mid_reset();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
